// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and PC helper for the fetch stage.
// Pure definitions: no latency, no flow control.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads an instruction or a bubble, 1-cycle latency.
// Stall holds contents; flush forces a bubble and wins over stall and load.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            // Decode consumes every cycle it is not stalled, so an empty slot becomes a bubble.
            if (i_load) begin
                r_instr    <= i_instr;
                r_pc       <= i_pc;
                r_pc_plus4 <= pc_plus4(i_pc);
                r_valid    <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one instruction per cycle with same-cycle ack, IF/ID 1 cycle after ack.
// Stalls park one fetched word in a buffer and drop the request; redirects squash in-flight reads.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBubble
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    fetch_state_e w_rst_state;
    logic [31:0]  r_pcf;
    logic [31:0]  r_buf_instr;
    logic [31:0]  r_buf_pc;
    logic         r_req_open;
    logic         r_fetch_bubble;

    logic [31:0]  w_pcf_nxt;
    logic [31:0]  w_target;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_load_pc;
    logic         w_load;
    logic         w_capture;
    logic         w_bubble;
    logic         w_unused_tgt_lsb;

    assign w_target         = {PCTargetE[31:2], 2'b00};
    assign w_unused_tgt_lsb = ^PCTargetE[1:0];

    assign IMemReq     = rst && (r_state != S_HOLD);
    assign IMemAddr    = r_pcf;
    assign FetchBubble = r_fetch_bubble;

    // A read still owed by memory when reset hits would otherwise be taken as the RESET_PC word.
    assign w_rst_state = (r_req_open && !IMemAck) ? S_KILL : S_FETCH;

    always_comb begin
        w_state_nxt  = r_state;
        w_pcf_nxt    = r_pcf;
        w_load       = 1'b0;
        w_load_instr = r_buf_instr;
        w_load_pc    = r_buf_pc;
        w_capture    = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (IMemAck) begin
                    if (!PCSrcE) begin
                        if (!StallF && !StallD) begin
                            w_load       = 1'b1;
                            w_load_instr = IMemRData;
                            w_load_pc    = r_pcf;
                            w_pcf_nxt    = pc_plus4(r_pcf);
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end else begin
                    w_bubble = !StallD;
                    if (PCSrcE) begin
                        w_state_nxt = S_KILL;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    w_state_nxt = S_FETCH;
                end else if (!StallF && !StallD) begin
                    w_load      = 1'b1;
                    w_pcf_nxt   = pc_plus4(r_pcf);
                    w_state_nxt = S_FETCH;
                end
            end
            S_KILL: begin
                if (IMemAck) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
        if (PCSrcE) begin
            w_pcf_nxt = w_target;
        end
    end

    // Tracks whether memory still owes an ack; deliberately kept running through reset.
    always_ff @(posedge clk) begin
        r_req_open <= (IMemReq || r_req_open) && !IMemAck;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= w_rst_state;
            r_pcf          <= {RESET_PC[31:2], 2'b00};
            r_buf_instr    <= 32'd0;
            r_buf_pc       <= 32'd0;
            r_fetch_bubble <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pcf          <= w_pcf_nxt;
            r_fetch_bubble <= w_bubble;
            if (w_capture) begin
                r_buf_instr <= IMemRData;
                r_buf_pc    <= r_pcf;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (StallD),
        .i_flush    (FlushD),
        .i_load     (w_load),
        .i_instr    (w_load_instr),
        .i_pc       (w_load_pc),
        .o_instr    (InstrD),
        .o_pc       (PCD),
        .o_pc_plus4 (PCPlus4D),
        .o_valid    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBubble;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: fetch address, parked word, squash pending, ack owed, expected IF/ID contents.
    logic [31:0] m_pc, m_hold_instr, m_hold_pc;
    bit          m_hold, m_squash, m_owe;
    logic [31:0] e_instr, e_pcd, e_pc4;
    bit          e_valid, e_bubble;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemRData   (IMemRData),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .FetchBubble (FetchBubble)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // One clock: drive inputs, check request outputs, ack, clock, update model, check IF/ID.
    task automatic step(input bit r, input bit sf, input bit sd, input bit fd, input bit ps,
                        input logic [31:0] tgt, input bit ackwish);
        bit          req, ack, got;
        logic [31:0] data, gi, gp;
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        #1;
        req = r && !m_hold;
        chk("IMemReq", {31'd0, IMemReq}, {31'd0, req});
        chk("IMemAddr", IMemAddr, m_pc);
        ack  = ackwish && (req || m_owe);
        data = mem_word(m_pc);
        IMemAck = ack; IMemRData = data;
        @(posedge clk);
        got = 0; gi = 32'd0; gp = 32'd0;
        if (!r) begin
            m_squash = m_owe && !ack;
            m_owe    = m_squash;
            m_hold   = 0;
            m_pc     = RST_PC;
            e_instr = NOP; e_pcd = 32'd0; e_pc4 = 32'd0; e_valid = 0; e_bubble = 0;
        end else begin
            e_bubble = 0;
            if (m_squash) begin
                if (ack) m_squash = 0;
            end else if (m_hold) begin
                if (ps) m_hold = 0;
                else if (!sf && !sd) begin
                    got = 1; gi = m_hold_instr; gp = m_hold_pc; m_hold = 0; m_pc = m_pc + 32'd4;
                end
            end else if (ack) begin
                if (!ps) begin
                    if (!sf && !sd) begin
                        got = 1; gi = data; gp = m_pc; m_pc = m_pc + 32'd4;
                    end else begin
                        m_hold = 1; m_hold_instr = data; m_hold_pc = m_pc;
                    end
                end
            end else begin
                e_bubble = !sd;
                if (ps) m_squash = 1;
            end
            if (ps) m_pc = {tgt[31:2], 2'b00};
            m_owe = (req || m_owe) && !ack;
            if (fd) begin
                e_instr = NOP; e_valid = 0;
            end else if (!sd) begin
                if (got) begin
                    e_instr = gi; e_pcd = gp; e_pc4 = gp + 32'd4; e_valid = 1;
                end else begin
                    e_instr = NOP; e_valid = 0;
                end
            end
        end
        #1;
        chk("InstrD", InstrD, e_instr);
        chk("PCD", PCD, e_pcd);
        chk("PCPlus4D", PCPlus4D, e_pc4);
        chk("ValidD", {31'd0, ValidD}, {31'd0, e_valid});
        chk("FetchBubble", {31'd0, FetchBubble}, {31'd0, e_bubble});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
        PCTargetE = 32'd0; IMemAck = 0; IMemRData = 32'd0;
        @(posedge clk); #1; IMemAck = 1;
        @(posedge clk); #1; IMemAck = 0;
        @(posedge clk); #1;
        m_pc = RST_PC; m_hold = 0; m_squash = 0; m_owe = 0;
        m_hold_instr = 32'd0; m_hold_pc = 32'd0;
        e_instr = NOP; e_pcd = 32'd0; e_pc4 = 32'd0; e_valid = 0; e_bubble = 0;

        chk("rst_InstrD", InstrD, NOP);
        chk("rst_PCD", PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
        chk("rst_FetchBubble", {31'd0, FetchBubble}, 32'd0);
        chk("rst_IMemReq", {31'd0, IMemReq}, 32'd0);
        chk("rst_IMemAddr", IMemAddr, RST_PC);

        // Back-to-back same-cycle acks
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 32'd0, 1);
            chk("seq_PCD", PCD, 32'(i * 4));
            chk("seq_ValidD", {31'd0, ValidD}, 32'd1);
            chk("seq_Bubble", {31'd0, FetchBubble}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 32'd0, 0);
        step(0, 0, 0, 0, 0, 32'd0, 0);

        // Ack delayed two cycles
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 32'd0, 0);
            chk("late_Bubble", {31'd0, FetchBubble}, 32'd1);
            chk("late_ValidD", {31'd0, ValidD}, 32'd0);
            chk("late_Addr", IMemAddr, 32'd0);
        end
        step(1, 0, 0, 0, 0, 32'd0, 1);
        chk("late_PCD", PCD, 32'd0);
        step(1, 0, 0, 0, 0, 32'd0, 1);

        // Stall on the ack at PC 8, then release
        step(1, 1, 1, 0, 0, 32'd0, 1);
        chk("hold_IMemReq", {31'd0, IMemReq}, 32'd0);
        chk("hold_PCD", PCD, 32'd4);
        step(1, 1, 1, 0, 0, 32'd0, 0);
        step(1, 0, 0, 0, 0, 32'd0, 0);
        chk("release_PCD", PCD, 32'd8);
        chk("release_Addr", IMemAddr, 32'd12);

        // Redirect with flush while the read is pending
        step(1, 0, 0, 1, 1, 32'h0000_0103, 0);
        chk("kill_ValidD", {31'd0, ValidD}, 32'd0);
        step(1, 0, 0, 0, 0, 32'd0, 1);
        chk("stale_ValidD", {31'd0, ValidD}, 32'd0);
        chk("redir_Addr", IMemAddr, 32'h0000_0100);
        step(1, 0, 0, 0, 0, 32'd0, 1);
        chk("redir_PCD", PCD, 32'h0000_0100);

        // PC wrap
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        step(1, 0, 0, 0, 0, 32'd0, 1);
        chk("wrap_PCD", PCD, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D", PCPlus4D, 32'd0);
        chk("wrap_Addr", IMemAddr, 32'd0);

        // Reset while holding a buffered word
        step(1, 0, 0, 0, 0, 32'd0, 1);
        step(1, 1, 1, 0, 0, 32'd0, 1);
        chk("hold2_IMemReq", {31'd0, IMemReq}, 32'd0);
        step(0, 1, 1, 0, 0, 32'd0, 0);
        chk("hrst_InstrD", InstrD, NOP);
        chk("hrst_PCD", PCD, 32'd0);
        chk("hrst_ValidD", {31'd0, ValidD}, 32'd0);
        chk("hrst_Addr", IMemAddr, RST_PC);
        chk("hrst_IMemReq", {31'd0, IMemReq}, 32'd0);

        // Randomized traffic, including occasional resets with reads in flight
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            bit          r;
            r   = ($urandom_range(99) != 0);
            tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(r, $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                 $urandom_range(9) == 0, tgt, $urandom_range(9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset: synchronous, active-low.
REQ-005 SHALL have port StallF  in  1  meaning hold PCF and do not consume a new instruction.
REQ-006 SHALL have port StallD  in  1  meaning hold the IF/ID register.
REQ-007 SHALL have port FlushD  in  1  meaning load a bubble into IF/ID.
REQ-008 SHALL have port PCSrcE  in  1  meaning redirect fetch to PCTargetE.
REQ-009 SHALL have port PCTargetE  in  32  meaning the branch/jump target from Execute.
REQ-010 SHALL have port IMemReq  out  1  meaning an instruction-memory read request.
REQ-011 SHALL have port IMemAddr  out  32  meaning the read address; equals PCF.
REQ-012 SHALL have port IMemAck  in  1  meaning read data valid; may assert in the same cycle as IMemReq.
REQ-013 SHALL have port IMemRData  in  32  meaning the instruction word, valid when IMemAck=1.
REQ-014 SHALL have port InstrD  out  32  meaning the IF/ID instruction.
REQ-015 SHALL have port PCD  out  32  meaning the IF/ID PC.
REQ-016 SHALL have port PCPlus4D  out  32  meaning the IF/ID PC+4.
REQ-017 SHALL have port ValidD  out  1  meaning IF/ID holds a real instruction.
REQ-018 SHALL have port FetchBubble  out  1  meaning IF/ID was loaded with a bubble this cycle because no instruction was available.

Function
REQ-019 SHALL implement FSM states FETCH (request outstanding), HOLD (instruction buffered, decode stalled) and KILL (outstanding request squashed).
REQ-020 SHALL drive IMemReq=1 in FETCH and KILL, drive IMemReq=0 in HOLD, and hold IMemAddr=PCF stable while IMemReq=1 without IMemAck.
REQ-021 In FETCH, on IMemAck=1 with StallF=0 and StallD=0, SHALL load InstrD=IMemRData, PCD=PCF, PCPlus4D=PCF+4 and ValidD=1, and set PCF=PCF+4, staying in FETCH (1 instruction/cycle with same-cycle ack).
REQ-022 In FETCH, on IMemAck=1 with StallF=1 or StallD=1, SHALL capture the word and its PC in a 1-entry buffer and go to HOLD.
REQ-023 In HOLD, when StallF=0 and StallD=0, SHALL move the buffer into IF/ID per REQ-021, set PCF=PCF+4 and return to FETCH.
REQ-024 In FETCH without IMemAck, with StallD=0, SHALL load IF/ID with NOP_INSTR and ValidD=0, and assert FetchBubble=1 for that cycle.
REQ-025 StallD=1 without FlushD SHALL hold all IF/ID outputs unchanged.
REQ-026 FlushD=1 SHALL load InstrD=NOP_INSTR and ValidD=0, overriding StallD and REQ-021/023, and SHALL drop any instruction that would have loaded.
REQ-027 PCSrcE=1 SHALL set PCF={PCTargetE[31:2],2'b00} regardless of StallF.
REQ-028 PCSrcE=1 in HOLD SHALL discard the buffer and go to FETCH.
REQ-029 PCSrcE=1 in FETCH with IMemAck=1 SHALL discard that data and stay in FETCH.
REQ-030 PCSrcE=1 in FETCH without IMemAck SHALL go to KILL.
REQ-031 In KILL, IMemAck SHALL be discarded and the state SHALL return to FETCH, issuing the redirected address next cycle; a PCSrcE in KILL only updates PCF.
REQ-032 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 0), and PCF[1:0] SHALL always be 00.

Reset
REQ-033 With rst=0 at a clock edge: PCF=RESET_PC; state FETCH; buffer empty; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; FetchBubble=0.
REQ-034 While rst=0, IMemReq SHALL be 0.
REQ-035 An ack for a request outstanding across reset SHALL be discarded, using the same mechanism as KILL.

Structure
REQ-036 A shared package SHALL hold RESET_PC, NOP_INSTR and the FSM state encoding.
REQ-037 The IF/ID register (stall/flush/load) SHALL be a sub-module if_id_reg; the FSM, PCF and buffer SHALL stay in fetch_stage.

Verification
REQ-038 Release reset, ack same cycle every cycle -> PCD sequence 0,4,8,12, ValidD=1 from the first ack, FetchBubble=0.
REQ-039 Ack delayed 2 cycles -> 2 cycles of FetchBubble=1/ValidD=0, then PCD=0; IMemAddr stable at 0 throughout.
REQ-040 StallF=StallD=1 on an ack at PC 8 -> HOLD, IMemReq=0, IF/ID unchanged; stall release -> PCD=8, next IMemAddr=12.
REQ-041 PCSrcE=1 with PCTargetE=0x103, FlushD=1, ack pending -> KILL, stale ack dropped, ValidD=0, next IMemAddr=0x100.
REQ-042 PCF=0xFFFF_FFFC with ack -> PCPlus4D=0, next IMemAddr=0; rst=0 mid-HOLD -> outputs per REQ-033, IMemAddr=RESET_PC.
